sec_counter: RTL and testbench

Seconds stage of the clock datapath: divides the system clock to a 1 Hz tick, keeps a BCD seconds count 00–59 and raises the minute-carry bit on each 59→00 wrap. `second` and `m_bit` feed the minute edge-qualification stage directly, which passes `m_bit` only while `second` reads 00. Run/stop, synchronous clear and a manual adjust input are handled here, so the minute path sees only clean, register-driven carries.

---
 rtl/sec_counter.sv | 94 +++++++++
 tb/tb_sec_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sec_counter.sv
// Seconds stage: divides clk to a 1 Hz tick, keeps a BCD 00-59 seconds count
// and raises a registered minute carry on each counted 59 -> 00 wrap.
module sec_counter #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clr,
    input  logic       adj,
    output logic [7:0] second,
    output logic       m_bit,
    output logic       tick
);

    localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PCNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [7:0]       second_q, second_d;
    logic             m_bit_q, m_bit_d;
    logic             tick_q, tick_d;
    logic             tick_en;
    logic [7:0]       second_inc;
    logic             wraps;

    // Any code outside 00-59 lands on 00 rather than propagating garbage.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        logic [7:0] r;
        tens  = v[7:4];
        units = v[3:0];
        if (tens > 4'd5 || units > 4'd9) begin
            r = 8'h00;
        end else if (units == 4'd9) begin
            r = (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, units + 4'd1};
        end
        return r;
    endfunction

    assign tick_en    = run && (pcnt_q == PCNT_LAST);
    assign second_inc = bcd_inc(second_q);
    assign wraps      = (second_q == 8'h59);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        pcnt_d   = pcnt_q;
        second_d = second_q;
        m_bit_d  = m_bit_q;
        tick_d   = 1'b0;

        if (clr) begin
            pcnt_d   = '0;
            second_d = 8'h00;
            m_bit_d  = 1'b0;
        end else if (adj) begin
            // A manual set restarts the second and never carries into minutes.
            pcnt_d   = '0;
            second_d = second_inc;
            m_bit_d  = 1'b0;
        end else if (tick_en) begin
            pcnt_d   = '0;
            second_d = second_inc;
            m_bit_d  = wraps;
            tick_d   = 1'b1;
        end else if (run) begin
            pcnt_d   = pcnt_q + PCNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q   <= '0;
            second_q <= 8'h00;
            m_bit_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            second_q <= second_d;
            m_bit_q  <= m_bit_d;
            tick_q   <= tick_d;
        end
    end

    assign second = second_q;
    assign m_bit  = m_bit_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_sec_counter.sv
// Directed bench for sec_counter with TICK_DIV=4; each task drives one scenario
// and compares outputs one time unit after the active edge.
module tb_sec_counter;

    logic       clk;
    logic       rst;
    logic       run;
    logic       clr;
    logic       adj;
    logic [7:0] second;
    logic       m_bit;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    sec_counter #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .clr    (clr),
        .adj    (adj),
        .second (second),
        .m_bit  (m_bit),
        .tick   (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b0; clr = 1'b0; adj = 1'b0;
        step(2);
        checks++;
        if (second !== 8'h00) begin failures++; $display("FAIL reset_second got=%h exp=00", second); end
        checks++;
        if (m_bit !== 1'b0) begin failures++; $display("FAIL reset_m_bit got=%b exp=0", m_bit); end
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        rst = 1'b0;
        run = 1'b1;
    endtask

    // Ticks on cycles 4, 8, ... and the seconds count goes 01..10 in BCD.
    task automatic test_free_run;
        for (int c = 1; c <= 40; c++) begin
            step(1);
            checks++;
            if (tick !== (c % 4 == 0)) begin
                failures++; $display("FAIL free_run_tick cycle=%0d got=%b exp=%b", c, tick, (c % 4 == 0));
            end
            checks++;
            if (second !== to_bcd(c / 4)) begin
                failures++; $display("FAIL free_run_second cycle=%0d got=%h exp=%h", c, second, to_bcd(c / 4));
            end
        end
    endtask

    task automatic test_minute_wrap;
        step(49 * 4);
        checks++;
        if (second !== 8'h59 || tick !== 1'b1) begin
            failures++; $display("FAIL wrap_at_59 got=%h/%b exp=59/1", second, tick);
        end
        step(3);
        checks++;
        if (m_bit !== 1'b0) begin failures++; $display("FAIL wrap_pre_m_bit got=%b exp=0", m_bit); end
        step(1);
        checks++;
        if (second !== 8'h00 || m_bit !== 1'b1 || tick !== 1'b1) begin
            failures++; $display("FAIL wrap_edge got=%h/%b/%b exp=00/1/1", second, m_bit, tick);
        end
        for (int c = 0; c < 3; c++) begin
            step(1);
            checks++;
            if (m_bit !== 1'b1 || second !== 8'h00) begin
                failures++; $display("FAIL wrap_m_bit_hold c=%0d got=%b/%h exp=1/00", c, m_bit, second);
            end
        end
        step(1);
        checks++;
        if (second !== 8'h01 || m_bit !== 1'b0 || tick !== 1'b1) begin
            failures++; $display("FAIL wrap_next got=%h/%b/%b exp=01/0/1", second, m_bit, tick);
        end
    endtask

    // Stop with pcnt=2 so the resumed second needs only two more cycles.
    task automatic test_pause;
        step(2);
        run = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            checks++;
            if (tick !== 1'b0 || second !== 8'h01) begin
                failures++; $display("FAIL pause_hold c=%0d got=%b/%h exp=0/01", c, tick, second);
            end
        end
        run = 1'b1;
        step(1);
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL pause_resume_early got=%b exp=0", tick); end
        step(1);
        checks++;
        if (tick !== 1'b1 || second !== 8'h02) begin
            failures++; $display("FAIL pause_resume_tick got=%b/%h exp=1/02", tick, second);
        end
    endtask

    task automatic test_adjust;
        adj = 1'b1;
        step(57);
        adj = 1'b0;
        checks++;
        if (second !== 8'h59 || m_bit !== 1'b0 || tick !== 1'b0) begin
            failures++; $display("FAIL adj_held got=%h/%b/%b exp=59/0/0", second, m_bit, tick);
        end
        adj = 1'b1;
        step(1);
        adj = 1'b0;
        checks++;
        if (second !== 8'h00 || m_bit !== 1'b0) begin
            failures++; $display("FAIL adj_wrap got=%h/%b exp=00/0", second, m_bit);
        end
        step(3);
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL adj_pcnt_early got=%b exp=0", tick); end
        step(1);
        checks++;
        if (tick !== 1'b1 || second !== 8'h01 || m_bit !== 1'b0) begin
            failures++; $display("FAIL adj_pcnt_tick got=%b/%h/%b exp=1/01/0", tick, second, m_bit);
        end
        step(16);
        checks++;
        if (second !== 8'h05) begin failures++; $display("FAIL adj_reach_05 got=%h exp=05", second); end
        step(3);
        adj = 1'b1;
        step(1);
        adj = 1'b0;
        checks++;
        if (second !== 8'h06 || tick !== 1'b0 || m_bit !== 1'b0) begin
            failures++; $display("FAIL adj_with_tick got=%h/%b/%b exp=06/0/0", second, tick, m_bit);
        end
        step(4);
        checks++;
        if (second !== 8'h07 || tick !== 1'b1) begin
            failures++; $display("FAIL adj_after_coinc got=%h/%b exp=07/1", second, tick);
        end
    endtask

    task automatic test_clear_priority;
        adj = 1'b1;
        step(52);
        adj = 1'b0;
        step(3);
        checks++;
        if (second !== 8'h59) begin failures++; $display("FAIL clr_setup got=%h exp=59", second); end
        clr = 1'b1;
        adj = 1'b1;
        step(1);
        clr = 1'b0;
        adj = 1'b0;
        checks++;
        if (second !== 8'h00 || m_bit !== 1'b0 || tick !== 1'b0) begin
            failures++; $display("FAIL clr_priority got=%h/%b/%b exp=00/0/0", second, m_bit, tick);
        end
        step(3);
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL clr_pcnt_early got=%b exp=0", tick); end
        step(1);
        checks++;
        if (tick !== 1'b1 || second !== 8'h01) begin
            failures++; $display("FAIL clr_next_tick got=%b/%h exp=1/01", tick, second);
        end
    endtask

    task automatic test_async_reset;
        adj = 1'b1;
        step(35);
        adj = 1'b0;
        step(4);
        checks++;
        if (second !== 8'h37 || tick !== 1'b1 || m_bit !== 1'b0) begin
            failures++; $display("FAIL arst_setup got=%h/%b/%b exp=37/1/0", second, tick, m_bit);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (second !== 8'h00 || m_bit !== 1'b0 || tick !== 1'b0) begin
            failures++; $display("FAIL arst_async got=%h/%b/%b exp=00/0/0", second, m_bit, tick);
        end
        step(2);
        rst = 1'b0;
        step(3);
        checks++;
        if (tick !== 1'b0 || second !== 8'h00) begin
            failures++; $display("FAIL arst_restart_early got=%b/%h exp=0/00", tick, second);
        end
        step(1);
        checks++;
        if (tick !== 1'b1 || second !== 8'h01) begin
            failures++; $display("FAIL arst_restart_tick got=%b/%h exp=1/01", tick, second);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_minute_wrap();
        test_pause();
        test_adjust();
        test_clear_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
